// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage with forwarding, branch resolve, iterative multiplier and EX/MEM register
module ex_mem_stage #(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWriteE,
   input  logic        ResultSrcE,
   input  logic        MemWriteE,
   input  logic        beqE,
   input  logic        ALUSrcE,
   input  logic        retE,
   input  logic [3:0]  FunctionE,
   input  logic [31:0] RD1E,
   input  logic [31:0] RD2E,
   input  logic [31:0] PCE,
   input  logic [31:0] ImmExtE,
   input  logic [4:0]  RdE,
   input  logic [1:0]  ForwardAE,
   input  logic [1:0]  ForwardBE,
   input  logic [31:0] ResultW,
   output logic        PCSrcE,
   output logic [31:0] PCTargetE,
   output logic        StallE,
   output logic        RegWriteM,
   output logic        ResultSrcM,
   output logic        MemWriteM,
   output logic [31:0] ALUResultM,
   output logic [31:0] WriteDataM,
   output logic [4:0]  RdM
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic [4:0] LAST = 5'(MUL_CYCLES - 1);
   localparam logic [3:0] OP_MUL = 4'b1010;
   state_t state, state_nx;
   logic [31:0] src_a, fwd_b, src_b, alu_res, mcand, mplier, acc;
   logic [4:0] cnt;
   logic is_mul;
   always_comb begin
      src_a = ForwardAE == 2'b01 ? ResultW : ForwardAE == 2'b10 ? ALUResultM : RD1E;
      fwd_b = ForwardBE == 2'b01 ? ResultW : ForwardBE == 2'b10 ? ALUResultM : RD2E;
      src_b = ALUSrcE ? ImmExtE : fwd_b;
   end
   always_comb begin
      case (FunctionE)
         4'b0000: alu_res = src_a + src_b;
         4'b0001: alu_res = src_a - src_b;
         4'b0010: alu_res = src_a & src_b;
         4'b0011: alu_res = src_a | src_b;
         4'b0100: alu_res = src_a ^ src_b;
         4'b0101: alu_res = src_a << src_b[4:0];
         4'b0110: alu_res = src_a >> src_b[4:0];
         4'b0111: alu_res = $signed(src_a) >>> src_b[4:0];
         4'b1000: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
         4'b1001: alu_res = {31'd0, src_a < src_b};
         OP_MUL:  alu_res = state == DONE ? acc : 32'd0;
         default: alu_res = 32'd0;
      endcase
   end
   assign PCSrcE = retE | (beqE & (src_a == fwd_b));
   assign PCTargetE = retE ? {src_a[31:1], 1'b0} : PCE + ImmExtE;
   assign is_mul = FunctionE == OP_MUL;
   always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = is_mul ? BUSY : IDLE;
         BUSY:    state_nx = cnt == LAST ? DONE : BUSY;
         default: state_nx = IDLE;
      endcase
   end
   always_comb StallE = (state == IDLE && is_mul) || state == BUSY;
   // operands are captured once on entry; the held D/E register keeps presenting MUL meanwhile
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand <= 32'd0;
         mplier <= 32'd0;
         acc <= 32'd0;
         cnt <= 5'd0;
      end else if (state == IDLE && is_mul) begin
         mcand <= src_a;
         mplier <= src_b;
         acc <= 32'd0;
         cnt <= 5'd0;
      end else if (state == BUSY) begin
         acc <= acc + (mplier[0] ? mcand : 32'd0);
         mcand <= mcand << 1;
         mplier <= mplier >> 1;
         cnt <= cnt + 5'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset || StallE) begin
         RegWriteM <= 1'b0;
         ResultSrcM <= 1'b0;
         MemWriteM <= 1'b0;
         ALUResultM <= 32'd0;
         WriteDataM <= 32'd0;
         RdM <= 5'd0;
      end else begin
         RegWriteM <= RegWriteE;
         ResultSrcM <= ResultSrcE;
         MemWriteM <= MemWriteE;
         ALUResultM <= alu_res;
         WriteDataM <= fwd_b;
         RdM <= RdE;
      end
   end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed scoreboard bench for the execute stage
module tb_ex_mem_stage;
   logic clk = 1'b0, reset = 1'b1;
   logic RegWriteE, ResultSrcE, MemWriteE, beqE, ALUSrcE, retE;
   logic [3:0] FunctionE;
   logic [31:0] RD1E, RD2E, PCE, ImmExtE, ResultW;
   logic [4:0] RdE;
   logic [1:0] ForwardAE, ForwardBE;
   logic PCSrcE, StallE, RegWriteM, ResultSrcM, MemWriteM;
   logic [31:0] PCTargetE, ALUResultM, WriteDataM;
   logic [4:0] RdM;
   int total = 0, bad = 0;
   typedef struct packed {
      logic rw, rs, mw;
      logic [31:0] alu, wd;
      logic [4:0] rd;
   } exp_t;
   exp_t q[$];
   logic [3:0]  tf [13] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'h1, 4'h0, 4'hF, 4'h5, 4'h8, 4'hB};
   logic [31:0] ta [13] = '{32'hF0F0, 32'hF0F0, 32'hFF, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h0, 32'hFFFFFFFF, 32'h5, 32'h3, 32'h1, 32'h5};
   logic [31:0] tb_ [13] = '{32'hFF00, 32'h0F0F, 32'h0F, 32'd31, 32'd4, 32'h1, 32'h1,
                             32'h1, 32'h2, 32'h6, 32'h21, 32'hFFFFFFFF, 32'h6};
   logic [31:0] te [13] = '{32'hF000, 32'hFFFF, 32'hF0, 32'h80000000, 32'h08000000, 32'h1, 32'h0,
                            32'hFFFFFFFF, 32'h1, 32'h0, 32'h6, 32'h0, 32'h0};

   ex_mem_stage dut (
      .clk(clk), .reset(reset), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
      .beqE(beqE), .ALUSrcE(ALUSrcE), .retE(retE), .FunctionE(FunctionE), .RD1E(RD1E), .RD2E(RD2E),
      .PCE(PCE), .ImmExtE(ImmExtE), .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE), .RegWriteM(RegWriteM),
      .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .RdM(RdM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      FunctionE = fn; RD1E = a; RD2E = b; RdE = rd;
      ALUSrcE = 1'b0; ImmExtE = 32'd0; ForwardAE = 2'b00; ForwardBE = 2'b00;
      RegWriteE = 1'b1; ResultSrcE = 1'b0; MemWriteE = 1'b0; beqE = 1'b0; retE = 1'b0; PCE = 32'd0;
   endtask

   task automatic push(input logic [31:0] alu, input logic [31:0] wd);
      exp_t e;
      e.rw = RegWriteE; e.rs = ResultSrcE; e.mw = MemWriteE; e.alu = alu; e.wd = wd; e.rd = RdE;
      q.push_back(e);
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      chk({tag, "_q"}, 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
         e = q.pop_front();
         chk({tag, "_alu"}, ALUResultM, e.alu);
         chk({tag, "_wd"}, WriteDataM, e.wd);
         chk({tag, "_ctl"}, {24'd0, RegWriteM, ResultSrcM, MemWriteM, RdM}, {24'd0, e.rw, e.rs, e.mw, e.rd});
      end
   endtask

   task automatic mul_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic [31:0] prod);
      int n;
      op(4'hA, a, b, rd);
      push(prod, b);
      #1;
      n = StallE ? 1 : 0;
      for (int i = 0; i < 40 && StallE; i++) begin
         if (i == 5) begin
            ForwardAE = 2'b01;
            ResultW = 32'hDEAD;
         end
         tick;
         chk("mul_bubble_alu", ALUResultM, 32'd0);
         chk("mul_bubble_rw", {31'd0, RegWriteM}, 32'd0);
         if (StallE) n++;
      end
      chk("mul_stall_cycles", 32'(n), 32'd33);
      tick;
      pop_chk("mul");
   endtask

   initial begin
      ResultW = 32'd0;
      op(4'h0, 32'd1, 32'd2, 5'd9);
      repeat (2) tick;
      chk("rst_stall", {31'd0, StallE}, 32'd0);
      chk("rst_alu", ALUResultM, 32'd0);
      chk("rst_wd", WriteDataM, 32'd0);
      chk("rst_ctl", {24'd0, RegWriteM, ResultSrcM, MemWriteM, RdM}, 32'd0);
      reset = 1'b0;
      op(4'h0, 32'd5, 32'd7, 5'd3); push(32'd12, 32'd7);
      #1 chk("add_stall", {31'd0, StallE}, 32'd0);
      tick; pop_chk("add");
      op(4'h0, 32'd60, 32'd40, 5'd5); push(32'd100, 32'd40);
      tick; pop_chk("add100");
      op(4'h1, 32'd1, 32'd2, 5'd6); ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd20; push(32'd80, 32'd20);
      tick; pop_chk("fwd_sub");
      op(4'h0, 32'd3, 32'd4, 5'd1); ForwardAE = 2'b11; ForwardBE = 2'b11; push(32'd7, 32'd4);
      tick; pop_chk("fwd11");
      op(4'h7, 32'h80000000, 32'h55, 5'd2); ALUSrcE = 1'b1; ImmExtE = 32'd4; push(32'hF8000000, 32'h55);
      tick; pop_chk("sra");
      for (int i = 0; i < 13; i++) begin
         op(tf[i], ta[i], tb_[i], 5'(i)); push(te[i], tb_[i]);
         tick; pop_chk("alu_tbl");
      end
      op(4'h0, 32'h100, 32'hABCD, 5'd0); RegWriteE = 1'b0; MemWriteE = 1'b1; ALUSrcE = 1'b1; ImmExtE = 32'd8;
      push(32'h108, 32'hABCD);
      tick; pop_chk("store");
      op(4'h0, 32'h200, 32'd0, 5'd5); ResultSrcE = 1'b1; ALUSrcE = 1'b1; ImmExtE = 32'd4; push(32'h204, 32'd0);
      tick; pop_chk("load");
      op(4'h0, 32'd9, 32'd9, 5'd0); RegWriteE = 1'b0; beqE = 1'b1; PCE = 32'h40; ImmExtE = 32'h10;
      push(32'd18, 32'd9);
      #1 chk("beq_taken", {31'd0, PCSrcE}, 32'd1);
      chk("beq_target", PCTargetE, 32'h50);
      tick; pop_chk("beq");
      op(4'h0, 32'd9, 32'd8, 5'd0); RegWriteE = 1'b0; beqE = 1'b1; PCE = 32'h40; ImmExtE = 32'h10;
      push(32'd17, 32'd8);
      #1 chk("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
      chk("beq_nt_target", PCTargetE, 32'h50);
      tick; pop_chk("beq_nt");
      op(4'h0, 32'h123, 32'h123, 5'd0); RegWriteE = 1'b0; retE = 1'b1; beqE = 1'b1; PCE = 32'h40; ImmExtE = 32'h10;
      push(32'h246, 32'h123);
      #1 chk("ret_taken", {31'd0, PCSrcE}, 32'd1);
      chk("ret_target", PCTargetE, 32'h122);
      tick; pop_chk("ret");
      mul_run(32'hFFFFFFFF, 32'd3, 5'd7, 32'hFFFFFFFD);
      op(4'h0, 32'd2, 32'd3, 5'd4); push(32'd5, 32'd3);
      #1 chk("after_mul_stall", {31'd0, StallE}, 32'd0);
      tick; pop_chk("after_mul");
      mul_run(32'd6, 32'd7, 5'd8, 32'd42);
      mul_run(32'h10000, 32'h10000, 5'd9, 32'd0);
      op(4'hA, 32'd7, 32'd9, 5'd4);
      repeat (11) tick;
      chk("busy_stall", {31'd0, StallE}, 32'd1);
      reset = 1'b1; FunctionE = 4'h0; RegWriteE = 1'b0;
      tick;
      chk("abort_stall", {31'd0, StallE}, 32'd0);
      chk("abort_alu", ALUResultM, 32'd0);
      chk("abort_ctl", {24'd0, RegWriteM, ResultSrcM, MemWriteM, RdM}, 32'd0);
      reset = 1'b0;
      mul_run(32'd5, 32'd5, 5'd10, 32'd25);
      op(4'h0, 32'd1, 32'd1, 5'd11); push(32'd2, 32'd1);
      tick; pop_chk("final");
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
